// File: rtl/result_checker.sv
// result_checker: self-check engine for CPU regression runs.
// After start it waits TIMEOUT cycles. It then compares NCHK probed values
// against expected values, one slot per cycle. For every enabled slot it
// streams a result record over a valid/ready port. At the end it holds a
// summary: done, pass, fail_mask and fail_count.
// Ports:
//   clk, reset (async, active-low)
//   start                           begin a run (only in IDLE/DONE)
//   probe_val, exp_val              packed slots, slot k at [k*WIDTH +: WIDTH]
//   chk_en                          per-slot enable
//   busy                            high in WAIT/CHECK/REPORT
//   rpt_valid/rpt_ready             record handshake
//   rpt_idx, rpt_got, rpt_exp, rpt_pass   record payload
//   done, pass, fail_mask, fail_count     run summary
module result_checker #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned NCHK         = 8,
  parameter int unsigned TIMEOUT      = 1000,
  parameter int unsigned STOP_ON_FAIL = 0,
  localparam int unsigned IW = (NCHK > 1) ? $clog2(NCHK) : 1,
  localparam int unsigned CW = $clog2(NCHK + 1),
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [NCHK*WIDTH-1:0] probe_val,
  input  logic [NCHK*WIDTH-1:0] exp_val,
  input  logic [NCHK-1:0]       chk_en,
  output logic                  busy,
  output logic                  rpt_valid,
  input  logic                  rpt_ready,
  output logic [IW-1:0]         rpt_idx,
  output logic [WIDTH-1:0]      rpt_got,
  output logic [WIDTH-1:0]      rpt_exp,
  output logic                  rpt_pass,
  output logic                  done,
  output logic                  pass,
  output logic [NCHK-1:0]       fail_mask,
  output logic [CW-1:0]         fail_count
);

  typedef enum logic [2:0] {IDLE, WAIT, CHECK, REPORT, DONE} state_t;

  state_t            state, state_nxt;
  logic [TW-1:0]     cnt, cnt_nxt;
  logic [IW-1:0]     idx, idx_nxt;
  logic              busy_nxt, rpt_valid_nxt, rpt_pass_nxt, done_nxt, pass_nxt;
  logic [IW-1:0]     rpt_idx_nxt;
  logic [WIDTH-1:0]  rpt_got_nxt, rpt_exp_nxt, slot_got, slot_exp;
  logic [NCHK-1:0]   fail_mask_nxt;
  logic [CW-1:0]     fail_count_nxt;
  logic              last_slot;

  assign slot_got  = probe_val[int'(idx)*WIDTH +: WIDTH];
  assign slot_exp  = exp_val[int'(idx)*WIDTH +: WIDTH];
  assign last_slot = (idx == IW'(NCHK - 1));

  // State register and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      busy       <= 1'b0;
      rpt_valid  <= 1'b0;
      rpt_idx    <= '0;
      rpt_got    <= '0;
      rpt_exp    <= '0;
      rpt_pass   <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_mask  <= '0;
      fail_count <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      busy       <= busy_nxt;
      rpt_valid  <= rpt_valid_nxt;
      rpt_idx    <= rpt_idx_nxt;
      rpt_got    <= rpt_got_nxt;
      rpt_exp    <= rpt_exp_nxt;
      rpt_pass   <= rpt_pass_nxt;
      done       <= done_nxt;
      pass       <= pass_nxt;
      fail_mask  <= fail_mask_nxt;
      fail_count <= fail_count_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    idx_nxt        = idx;
    rpt_valid_nxt  = rpt_valid;
    rpt_idx_nxt    = rpt_idx;
    rpt_got_nxt    = rpt_got;
    rpt_exp_nxt    = rpt_exp;
    rpt_pass_nxt   = rpt_pass;
    fail_mask_nxt  = fail_mask;
    fail_count_nxt = fail_count;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt      = WAIT;
          cnt_nxt        = TW'(TIMEOUT - 1);
          idx_nxt        = '0;
          rpt_valid_nxt  = 1'b0;
          rpt_idx_nxt    = '0;
          rpt_got_nxt    = '0;
          rpt_exp_nxt    = '0;
          rpt_pass_nxt   = 1'b0;
          fail_mask_nxt  = '0;
          fail_count_nxt = '0;
        end
      end
      WAIT: begin
        if (cnt == '0) state_nxt = CHECK;
        else           cnt_nxt   = cnt - TW'(1);
      end
      CHECK: begin
        if (chk_en[idx]) begin
          // Capture the slot now; later probe changes must not alter the record.
          state_nxt     = REPORT;
          rpt_valid_nxt = 1'b1;
          rpt_idx_nxt   = idx;
          rpt_got_nxt   = slot_got;
          rpt_exp_nxt   = slot_exp;
          rpt_pass_nxt  = (slot_got == slot_exp);
          if (slot_got != slot_exp) begin
            fail_mask_nxt[idx] = 1'b1;
            if (fail_count != CW'(NCHK)) fail_count_nxt = fail_count + CW'(1);
          end
        end else if (last_slot) begin
          state_nxt = DONE;
        end else begin
          idx_nxt = idx + IW'(1);
        end
      end
      REPORT: begin
        if (rpt_ready) begin
          rpt_valid_nxt = 1'b0;
          if (last_slot || ((STOP_ON_FAIL != 0) && !rpt_pass)) begin
            state_nxt = DONE;
          end else begin
            state_nxt = CHECK;
            idx_nxt   = idx + IW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Status outputs follow the state being entered so they line up with it.
    busy_nxt = (state_nxt == WAIT) || (state_nxt == CHECK) || (state_nxt == REPORT);
    done_nxt = (state_nxt == DONE);
    pass_nxt = done_nxt && (fail_count_nxt == '0);
  end

endmodule
